// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache with one-word lines.
// Hits complete combinationally; misses stall while the FSM writes back and refills the line.
module dcache_ctrl #(
  parameter int INDEX_BITS = 6,
  parameter int MEM_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] wrt_data,
  output logic [15:0] rd_data,
  output logic        stall,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [15:0] mem_wrt_data,
  input  logic [15:0] mem_rd_data
);

  localparam int         LINES = 1 << INDEX_BITS;
  localparam int         TAG_W = 16 - INDEX_BITS;
  localparam logic [3:0] LAST  = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [15:0]       r_data [LINES];

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_access;
  logic                  w_hit;
  logic                  w_rd_hit;
  logic                  w_wr_hit;
  logic                  w_last;

  assign w_idx    = addr[INDEX_BITS-1:0];
  assign w_tag    = addr[15:INDEX_BITS];
  assign w_access = re ^ we;
  assign w_hit    = w_access && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_rd_hit = (r_state == IDLE) && w_hit && re;
  assign w_wr_hit = (r_state == IDLE) && w_hit && we;
  assign w_last   = (r_cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wr_hit) begin
            r_dirty[w_idx] <= 1'b1;
          end else if (w_access && !w_hit) begin
            r_cnt   <= 4'd0;
            r_state <= (r_valid[w_idx] && r_dirty[w_idx]) ? WB : FILL;
          end
        end
        WB: begin
          if (w_last) begin
            r_dirty[w_idx] <= 1'b0;
            r_cnt          <= 4'd0;
            r_state        <= FILL;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        FILL: begin
          if (w_last) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
            r_cnt          <= 4'd0;
            r_state        <= IDLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone make their contents meaningful.
  always_ff @(posedge clk) begin
    if (w_wr_hit) begin
      r_data[w_idx] <= wrt_data;
    end else if ((r_state == FILL) && w_last) begin
      r_data[w_idx] <= mem_rd_data;
      r_tag[w_idx]  <= w_tag;
    end
  end

  // NOTE: every output gets a default first so this block never infers a latch.
  always_comb begin
    rd_data      = 16'd0;
    stall        = 1'b0;
    mem_addr     = 16'd0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_wrt_data = 16'd0;
    // Gating with rst_n keeps stall low even if the CPU holds a request through reset.
    if (rst_n) begin
      stall = (r_state != IDLE) || (w_access && !w_hit);
      if (w_rd_hit) rd_data = r_data[w_idx];
      case (r_state)
        WB: begin
          mem_we       = 1'b1;
          mem_addr     = {r_tag[w_idx], w_idx};
          mem_wrt_data = r_data[w_idx];
        end
        FILL: begin
          mem_re   = 1'b1;
          mem_addr = addr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: the driver queues the expected outcome of each access,
// and a negedge monitor tallies stall/strobe activity and checks it when the access completes.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr, wrt_data, rd_data, mem_addr, mem_wrt_data, mem_rd_data;
  logic        re, we, stall, mem_re, mem_we;

  logic [15:0] mem_model [65536];

  typedef struct {
    logic [15:0] rd;
    int          n_stall;
    int          n_we;
    logic [15:0] wb_addr;
    logic [15:0] wb_data;
    int          n_re;
    logic [15:0] fill_addr;
  } exp_t;

  exp_t sb [$];

  int n_vec  = 0;
  int n_fail = 0;

  int cnt_stall, cnt_re, cnt_we;
  bit bad_wb, bad_fill, bad_idle, bad_ovl;

  dcache_ctrl #(.INDEX_BITS(6), .MEM_LAT(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .re           (re),
    .we           (we),
    .wrt_data     (wrt_data),
    .rd_data      (rd_data),
    .stall        (stall),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_wrt_data (mem_wrt_data),
    .mem_rd_data  (mem_rd_data)
  );

  always #5 clk = ~clk;

  assign mem_rd_data = mem_re ? mem_model[mem_addr] : 16'd0;

  always @(posedge clk) begin
    if (mem_we) mem_model[mem_addr] <= mem_wrt_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] rd, input int n_stall, input int n_we,
                              input logic [15:0] wb_addr, input logic [15:0] wb_data,
                              input int n_re, input logic [15:0] fill_addr);
    exp_t e;
    e.rd = rd; e.n_stall = n_stall; e.n_we = n_we; e.wb_addr = wb_addr;
    e.wb_data = wb_data; e.n_re = n_re; e.fill_addr = fill_addr;
    return e;
  endfunction

  task automatic clear_mon();
    cnt_stall = 0; cnt_re = 0; cnt_we = 0;
    bad_wb = 0; bad_fill = 0; bad_idle = 0; bad_ovl = 0;
  endtask

  // Monitor: accumulates per-access activity and compares when stall drops with a request up.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      clear_mon();
    end else begin
      if (mem_re && mem_we) bad_ovl = 1;
      if (stall) cnt_stall++;
      if (mem_we) begin
        cnt_we++;
        if (sb.size() > 0 && (mem_addr != sb[0].wb_addr || mem_wrt_data != sb[0].wb_data)) bad_wb = 1;
      end
      if (mem_re) begin
        cnt_re++;
        if (sb.size() > 0 && mem_addr != sb[0].fill_addr) bad_fill = 1;
      end
      if (!mem_re && !mem_we && (mem_addr != 16'd0 || mem_wrt_data != 16'd0)) bad_idle = 1;
      if ((re || we) && !stall) begin
        if (sb.size() == 0) begin
          check("unexpected_completion", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rd_data", rd_data, e.rd);
          check("stall_cycles", cnt_stall, e.n_stall);
          check("mem_we_cycles", cnt_we, e.n_we);
          check("mem_re_cycles", cnt_re, e.n_re);
          check("wb_addr_data", bad_wb, 0);
          check("fill_addr", bad_fill, 0);
          check("idle_mem_bus_zero", bad_idle, 0);
          check("re_we_overlap", bad_ovl, 0);
        end
        clear_mon();
      end
    end
  end

  task automatic do_access(input logic [15:0] a, input logic r, input logic w,
                           input logic [15:0] d, input exp_t e);
    bit done;
    sb.push_back(e);
    @(posedge clk); #1;
    addr = a; re = r; we = w; wrt_data = d;
    done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      check("access_timeout", 0, 1);
      sb.delete();
    end
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0;
  endtask

  initial begin
    mem_model[16'h0010] = 16'h1234;
    mem_model[16'h0050] = 16'h5678;
    mem_model[16'h0020] = 16'hCAFE;
    rst_n = 1'b0; addr = 16'd0; re = 1'b0; we = 1'b0; wrt_data = 16'd0;
    clear_mon();
    #1;
    check("reset_stall", stall, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_mem_re", mem_re, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_mem_wrt_data", mem_wrt_data, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Cold read miss, then read hit.
    do_access(16'h0010, 1, 0, 16'h0000, mk(16'h1234, 3, 0, 16'h0, 16'h0, 2, 16'h0010));
    do_access(16'h0010, 1, 0, 16'h0000, mk(16'h1234, 0, 0, 16'h0, 16'h0, 0, 16'h0));
    // Write hit leaves memory stale.
    do_access(16'h0010, 0, 1, 16'hBEEF, mk(16'h0000, 0, 0, 16'h0, 16'h0, 0, 16'h0));
    check("mem_0010_after_write_hit", mem_model[16'h0010], 16'h1234);
    do_access(16'h0010, 1, 0, 16'h0000, mk(16'hBEEF, 0, 0, 16'h0, 16'h0, 0, 16'h0));
    // Dirty eviction of 0x0010 by 0x0050.
    do_access(16'h0050, 1, 0, 16'h0000, mk(16'h5678, 5, 2, 16'h0010, 16'hBEEF, 2, 16'h0050));
    check("mem_0010_after_evict", mem_model[16'h0010], 16'hBEEF);
    // re && we together is ignored.
    do_access(16'h0050, 1, 1, 16'hAAAA, mk(16'h0000, 0, 0, 16'h0, 16'h0, 0, 16'h0));
    do_access(16'h0050, 1, 0, 16'h0000, mk(16'h5678, 0, 0, 16'h0, 16'h0, 0, 16'h0));

    // Reset during the second FILL cycle of a read of 0x0020.
    @(posedge clk); #1;
    addr = 16'h0020; re = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    check("mid_fill_mem_re_before_reset", mem_re, 1);
    rst_n = 1'b0;
    #1;
    check("mid_fill_reset_mem_re", mem_re, 0);
    check("mid_fill_reset_stall", stall, 0);
    check("mid_fill_reset_mem_addr", mem_addr, 0);
    @(posedge clk); @(posedge clk); #1;
    re = 1'b0;
    rst_n = 1'b1;

    // Every line is invalid again.
    do_access(16'h0050, 1, 0, 16'h0000, mk(16'h5678, 3, 0, 16'h0, 16'h0, 2, 16'h0050));
    // Write miss on a clean line, then evict it dirty.
    do_access(16'h0090, 0, 1, 16'h7777, mk(16'h0000, 3, 0, 16'h0, 16'h0, 2, 16'h0090));
    do_access(16'h0090, 1, 0, 16'h0000, mk(16'h7777, 0, 0, 16'h0, 16'h0, 0, 16'h0));
    do_access(16'h0010, 1, 0, 16'h0000, mk(16'hBEEF, 5, 2, 16'h0090, 16'h7777, 2, 16'h0010));
    check("mem_0090_after_evict", mem_model[16'h0090], 16'h7777);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache between the pipeline MEM stage and the 16-bit word-addressed data memory. Read and write hits complete with no stall. On a miss the block stalls the pipeline, writes back a dirty victim if there is one, fills the line from data memory, and then lets the access finish. On the memory side it drives the data memory's single-ported read/write interface and never asserts read and write together.

## Interface
- INDEX_BITS, 6: number of index bits; the cache has 2^INDEX_BITS one-word lines and the tag is 16-INDEX_BITS bits.
- MEM_LAT, 2: number of cycles each memory strobe is held; legal range 1..15.

- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  16  CPU word address.
- re  in  1  CPU read request.
- we  in  1  CPU write request.
- wrt_data  in  16  CPU store data.
- rd_data  out  16  load data; valid when re && !stall.
- stall  out  1  freeze the pipeline; the CPU holds addr/re/we/wrt_data stable while it is high.
- mem_addr  out  16  data memory address.
- mem_re  out  1  data memory read strobe.
- mem_we  out  1  data memory write strobe.
- mem_wrt_data  out  16  data memory write data.
- mem_rd_data  in  16  data memory read data.

## Operation
- Per line: valid, dirty, tag[15:INDEX_BITS], data[15:0]. Index = addr[INDEX_BITS-1:0].
- Only valid and dirty are reset. Tag and data arrays are not reset.
- Access = re XOR we. re && we together is ignored: no stall, no state change, rd_data = 0.
- hit = access && valid[idx] && tag[idx] == addr[15:INDEX_BITS]. This is combinational.
- FSM states are IDLE, WB and FILL. A 4-bit counter cnt counts 0..MEM_LAT-1.
- IDLE
  - Read hit: rd_data = data[idx].
  - Write hit: data[idx] <= wrt_data and dirty <= 1 at the edge.
  - Miss, victim valid && dirty: go to WB with cnt = 0.
  - Miss, otherwise: go to FILL with cnt = 0.
- WB
  - Drive mem_we = 1, mem_addr = {tag[idx], idx}, mem_wrt_data = data[idx].
  - When cnt == MEM_LAT-1: dirty[idx] <= 0 and go to FILL with cnt = 0.
- FILL
  - Drive mem_re = 1, mem_addr = addr.
  - When cnt == MEM_LAT-1: data[idx] <= mem_rd_data, tag <= addr tag, valid <= 1, dirty <= 0, then go to IDLE.
- Back in IDLE the pending access hits and completes: a write merges and sets dirty.
- stall = (state != IDLE) || (access && !hit).
- rd_data = 0 whenever the cycle is not a read hit.
- mem_addr and mem_wrt_data = 0 in IDLE. mem_re and mem_we are never high together.

## Timing
- Reset values:
  - stall = 0, rd_data = 0, mem_re = 0, mem_we = 0, mem_addr = 0, mem_wrt_data = 0.
  - state = IDLE, cnt = 0, all valid and dirty bits = 0.
- Hit latency: 0. stall stays low and rd_data is valid in the same cycle.
- Clean miss: stall is high for MEM_LAT+1 cycles and mem_re for MEM_LAT cycles.
- Dirty miss: stall is high for 2*MEM_LAT+1 cycles. mem_we runs for MEM_LAT cycles, then mem_re for MEM_LAT cycles back-to-back, with no idle cycle between them.
- mem_rd_data is sampled only on the last FILL cycle.
- Reset asserted mid-WB or mid-FILL:
  - All outputs go to their reset values immediately, without waiting for a clock.
  - The partial write-back is abandoned and dirty data is lost.
  - After release every access misses.
- An access whose index matches a line being written back is handled: the tag mismatch is already established, and the victim is read before FILL overwrites it.

## Test plan
Parameters: INDEX_BITS = 6, MEM_LAT = 2. Memory preloaded with [0x0010] = 0x1234 and [0x0050] = 0x5678.
- Cold read miss: reset, then read 0x0010. Required: stall high for 3 cycles; mem_re high for 2 cycles with mem_addr = 0x0010; then rd_data = 0x1234 with stall = 0.
- Read hit: read 0x0010 again. Required: stall = 0, mem_re = 0, rd_data = 0x1234 in the same cycle.
- Write hit: write 0x0010 = 0xBEEF. Required: no stall, no mem_we. A following read returns 0xBEEF while memory still holds 0x1234.
- Dirty eviction: read 0x0050 (same index 0x10). Required:
  - mem_we for 2 cycles, mem_addr = 0x0010, mem_wrt_data = 0xBEEF.
  - Then mem_re for 2 cycles, mem_addr = 0x0050.
  - stall for 5 cycles, then rd_data = 0x5678; memory[0x0010] = 0xBEEF.
- re && we together at 0x0050: no stall, no memory strobes, rd_data = 0.
- Reset during the 2nd FILL cycle of a read of 0x0020: mem_re and stall drop asynchronously. After release, a read of 0x0050 misses again with 3 stall cycles.
